apb_rr_requester_arb: RTL

- Round-robin arbiter and sequencer that shares the single 8-bit APB master between NREQ local requesters.
- Latches the winning request and drives the master's transfer, mpwrite, address and write-data inputs.
- Detects the end of the ACCESS phase from the bus handshake, captures read data, and returns a one-cycle done pulse to the winning requester.
- Sits between the requester logic and apb_master in the APB subsystem.

---
 rtl/apb_pkg.sv | 10 +
 rtl/rr_pick.sv | 23 ++
 rtl/apb_rr_requester_arb.sv | 91 +++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// apb_pkg: shared arbiter state encoding and default bus widths for the APB subsystem
package apb_pkg;
  localparam int DEF_AW = 8;
  localparam int DEF_DW = 8;
  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_XFER = 2'b01,
    ARB_DONE = 2'b10
  } arb_state_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, first set req bit searching upward from ptr with wrap
// Ports: req (request vector), ptr (search start) -> valid (any request), grant (one-hot winner), idx (winner index)
module rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic                    valid,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] idx
);
  localparam int IW = $clog2(NREQ);
  logic [NREQ-1:0] rot;
  // rot[j] is requester (ptr + j) mod NREQ, so the lowest set bit of rot is the winner
  assign rot = NREQ'({req, req} >> ptr);
  assign valid = |req;
  assign grant = valid ? NREQ'(1) << idx : '0;
  always_comb begin
    idx = '0;
    for (int j = NREQ - 1; j >= 0; j--)
      if (rot[j]) idx = IW'((int'(ptr) + j) % NREQ);
  end
endmodule

// File: rtl/apb_rr_requester_arb.sv
// apb_rr_requester_arb: round-robin arbiter/sequencer sharing one APB master among NREQ requesters
// Ports: pclk/presetn clock and async active-low reset; req/req_write/req_addr/req_wdata requester side;
//        gnt/done/rdata/busy requester results; transfer/mpwrite/apb_*_paddr/apb_write_data to the master;
//        psel/penable/pready/apb_read_data_out bus handshake and read data from the master/slave
module apb_rr_requester_arb
  import apb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int AW   = DEF_AW,
  parameter int DW   = DEF_DW
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_write,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [DW-1:0]     rdata,
  output logic              busy,
  output logic              transfer,
  output logic              mpwrite,
  output logic [AW-1:0]     apb_write_paddr,
  output logic [AW-1:0]     apb_read_paddr,
  output logic [DW-1:0]     apb_write_data,
  input  logic              psel,
  input  logic              penable,
  input  logic              pready,
  input  logic [DW-1:0]     apb_read_data_out
);
  localparam int IW = $clog2(NREQ);
  arb_state_t      state;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   pick_idx;
  logic [NREQ-1:0] pick_gnt;
  logic            pick_valid;
  logic            wr_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic            xfer_done;
  rr_pick #(.NREQ(NREQ)) u_pick (
    .req  (req),
    .ptr  (rr_ptr),
    .valid(pick_valid),
    .grant(pick_gnt),
    .idx  (pick_idx)
  );
  assign xfer_done       = psel & penable & pready;
  assign busy            = state != ARB_IDLE;
  // low during ACCESS so the master drops back to IDLE after this single transfer
  assign transfer        = (state == ARB_XFER) & ~(psel & penable);
  assign done            = (state == ARB_DONE) ? gnt : '0;
  assign mpwrite         = wr_q;
  assign apb_write_paddr = addr_q;
  assign apb_read_paddr  = addr_q;
  assign apb_write_data  = wdata_q;
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state   <= ARB_IDLE;
      rr_ptr  <= '0;
      win_idx <= '0;
      gnt     <= '0;
      rdata   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      case (state)
        ARB_IDLE: if (pick_valid) begin
          state   <= ARB_XFER;
          gnt     <= pick_gnt;
          win_idx <= pick_idx;
          wr_q    <= req_write[pick_idx];
          addr_q  <= req_addr[pick_idx*AW +: AW];
          wdata_q <= req_wdata[pick_idx*DW +: DW];
        end
        ARB_XFER: if (xfer_done) begin
          state  <= ARB_DONE;
          rr_ptr <= (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
          if (!wr_q) rdata <= apb_read_data_out;
        end
        default: begin
          state <= ARB_IDLE;
          gnt   <= '0;
        end
      endcase
    end
  end
endmodule
